conf_stream_loader: RTL

- Upstream feeder of the accelerator's configuration register file.
- Accepts a valid/ready stream of 32-bit words from the host/uDMA side and parses it into burst headers plus data words.
- Issues one register-file write per accepted data word on the wr_en_ext / wr_addr_ext / wr_data_ext bus.
- Signals completion of a configuration session and flags malformed streams.

---
 rtl/conf_stream_loader_pkg.sv | 25 ++
 rtl/conf_stream_loader.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/conf_stream_loader_pkg.sv
// ---------------------------------------------------------------------------
// conf_stream_loader_pkg
// Shared constants and types for the configuration stream loader:
//   - CONF_REGISTERS_SIZE : number of writable configuration registers
//   - OP_WRITE / OP_END   : header opcodes
//   - ERR_BAD_OP / ERR_RANGE : err_code encodings
//   - loader_state_e      : loader FSM state encoding
// ---------------------------------------------------------------------------
package conf_stream_loader_pkg;

  localparam int CONF_REGISTERS_SIZE = 8;

  localparam logic [7:0] OP_WRITE = 8'hC0;
  localparam logic [7:0] OP_END   = 8'hE0;

  localparam logic [1:0] ERR_BAD_OP = 2'b01;
  localparam logic [1:0] ERR_RANGE  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    DRAIN = 2'd2
  } loader_state_e;

endpackage

// File: rtl/conf_stream_loader.sv
// ---------------------------------------------------------------------------
// conf_stream_loader
// Parses a valid/ready stream of 32-bit words into burst headers and data
// words and issues one configuration register-file write per data word.
// Header layout: [31:24] opcode, [15:8] start address, [7:0] count.
//
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   in_valid      : stream word valid
//   in_ready      : loader accepts the word (low only during reset)
//   in_data       : stream word
//   clear_err     : one-cycle pulse clearing err / err_code
//   wr_en_ext     : register-file write strobe (registered)
//   wr_addr_ext   : register-file write address (registered, held)
//   wr_data_ext   : register-file write data (registered, held)
//   conf_done     : one-cycle pulse after an END header is accepted
//   busy          : high while a burst (DATA or DRAIN) is in progress
//   err           : sticky error flag
//   err_code      : 01 bad opcode, 10 address range; first error kept
// ---------------------------------------------------------------------------
module conf_stream_loader
  import conf_stream_loader_pkg::*;
#(
  parameter int CONF_REGISTERS_SIZE = conf_stream_loader_pkg::CONF_REGISTERS_SIZE,
  parameter int CNT_W               = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        clear_err,
  output logic        wr_en_ext,
  output logic [31:0] wr_addr_ext,
  output logic [31:0] wr_data_ext,
  output logic        conf_done,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_code
);

  // Range check is done one bit wider than the widest operand so that a
  // large start plus a large count can never wrap into the legal window.
  localparam int SUM_W = ((CNT_W > 8) ? CNT_W : 8) + 1;
  localparam logic [SUM_W-1:0] REG_LIMIT = SUM_W'(CONF_REGISTERS_SIZE);

  loader_state_e    state_r;
  logic [7:0]       addr_r;
  logic [CNT_W-1:0] rem_r;
  logic             wr_en_r;
  logic [31:0]      wr_addr_r;
  logic [31:0]      wr_data_r;
  logic             conf_done_r;
  logic             err_r;
  logic [1:0]       err_code_r;

  logic             xfer_s;
  logic [7:0]       opcode_s;
  logic [7:0]       start_s;
  logic [CNT_W-1:0] cnt_s;
  logic [SUM_W-1:0] end_s;
  logic             range_bad_s;
  logic             cnt_zero_s;
  logic             load_code_s;

  assign in_ready = ~reset;
  assign xfer_s   = in_valid & in_ready;

  // Header field decode and range check of the word currently on in_data.
  always_comb begin
    opcode_s    = in_data[31:24];
    start_s     = in_data[15:8];
    cnt_s       = in_data[CNT_W-1:0];
    end_s       = SUM_W'(start_s) + SUM_W'(cnt_s);
    range_bad_s = (end_s > REG_LIMIT);
    cnt_zero_s  = (cnt_s == {CNT_W{1'b0}});
    // A new error code is loaded when no error is latched, or when the
    // latched one is being cleared in this very cycle (new error wins).
    load_code_s = (~err_r) | clear_err;
  end

  // Loader FSM with all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      addr_r      <= 8'd0;
      rem_r       <= {CNT_W{1'b0}};
      wr_en_r     <= 1'b0;
      wr_addr_r   <= 32'd0;
      wr_data_r   <= 32'd0;
      conf_done_r <= 1'b0;
      err_r       <= 1'b0;
      err_code_r  <= 2'b00;
    end else begin
      wr_en_r     <= 1'b0;
      conf_done_r <= 1'b0;

      // Clear first; an error raised below in the same cycle overrides it.
      if (clear_err) begin
        err_r      <= 1'b0;
        err_code_r <= 2'b00;
      end

      case (state_r)
        IDLE: begin
          if (xfer_s) begin
            case (opcode_s)
              OP_WRITE: begin
                if (cnt_zero_s) begin
                  state_r <= IDLE;
                end else if (range_bad_s) begin
                  err_r <= 1'b1;
                  if (load_code_s) begin
                    err_code_r <= ERR_RANGE;
                  end
                  rem_r   <= cnt_s;
                  state_r <= DRAIN;
                end else begin
                  addr_r  <= start_s;
                  rem_r   <= cnt_s;
                  state_r <= DATA;
                end
              end
              OP_END: begin
                conf_done_r <= 1'b1;
              end
              default: begin
                err_r <= 1'b1;
                if (load_code_s) begin
                  err_code_r <= ERR_BAD_OP;
                end
              end
            endcase
          end
        end
        DATA: begin
          if (xfer_s) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= {24'd0, addr_r};
            wr_data_r <= in_data;
            addr_r    <= addr_r + 8'd1;
            rem_r     <= rem_r - CNT_W'(1);
            if (rem_r == CNT_W'(1)) begin
              state_r <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (xfer_s) begin
            rem_r <= rem_r - CNT_W'(1);
            if (rem_r == CNT_W'(1)) begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign wr_en_ext   = wr_en_r;
  assign wr_addr_ext = wr_addr_r;
  assign wr_data_ext = wr_data_r;
  assign conf_done   = conf_done_r;
  assign busy        = (state_r != IDLE);
  assign err         = err_r;
  assign err_code    = err_code_r;

endmodule
